// File: rtl/y86_pkg.sv
// y86_pkg: constants and types shared by the Y86-64 pipeline control logic
// and the stage registers.
//   - icode constants used by the hazard logic
//   - RNONE: register ID that means "no register"
//   - stat_t: architectural status codes
//   - fsm_state_t: run-state machine encoding for pipe_ctrl
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE    = 4'hF;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_STOPPED = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/pipe_hazard.sv
// pipe_hazard: purely combinational hazard detection.
// Inputs : D_icode, d_srcA, d_srcB (decode), E_icode, E_dstM, e_cnd (execute),
//          M_icode (memory).
// Outputs: load_use - load in E writes a register that D is about to read
//          ret_pend - a RET is somewhere in D, E or M
//          mispred  - a conditional jump in E was predicted taken but is not
module pipe_hazard
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_cnd,
  input  logic [3:0] M_icode,
  output logic       load_use,
  output logic       ret_pend,
  output logic       mispred
);

  logic e_is_load;

  assign e_is_load = (E_icode == I_MRMOVQ) || (E_icode == I_POPQ);

  // RNONE guard keeps "no source" in decode from matching "no destination".
  assign load_use = e_is_load && (E_dstM != RNONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));

  assign ret_pend = (D_icode == I_RET) || (E_icode == I_RET) ||
                    (M_icode == I_RET);

  // Jumps are predicted taken, so a false condition means a mispredict.
  assign mispred  = (E_icode == I_JXX) && !e_cnd;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the five-stage Y86-64 core.
// Inputs : clk, rst (sync, active high), pipeline-register icodes / register
//          IDs / status codes from D, E, M and W, plus e_cnd from execute.
// Outputs: F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble to the
//          stage registers; halted and stat_out for the architectural stop;
//          cyc_cnt, stall_cnt, bubble_cnt, mispred_cnt performance counters.
// The run-state machine goes RUN -> DRAIN when a fault shows up in memory,
// and -> STOPPED once a non-AOK status reaches write-back.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_cnd,
  input  logic [3:0]       M_icode,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             halted,
  output logic [1:0]       stat_out,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int NUM_CNT = 4;

  logic load_use;
  logic ret_pend;
  logic mispred;
  logic exc_m;
  logic exc_w;

  fsm_state_t state_reg;
  fsm_state_t state_next;
  logic [1:0] stat_reg;
  logic [1:0] stat_next;

  pipe_hazard u_hazard (
    .D_icode  (D_icode),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .E_icode  (E_icode),
    .E_dstM   (E_dstM),
    .e_cnd    (e_cnd),
    .M_icode  (M_icode),
    .load_use (load_use),
    .ret_pend (ret_pend),
    .mispred  (mispred)
  );

  assign exc_m = (m_stat != STAT_AOK);
  assign exc_w = (W_stat != STAT_AOK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      stat_reg  <= STAT_AOK;
    end else begin
      state_reg <= state_next;
      stat_reg  <= stat_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stat_next  = stat_reg;
    F_stall    = 1'b0;
    D_stall    = 1'b0;
    W_stall    = 1'b0;
    D_bubble   = 1'b0;
    E_bubble   = 1'b0;
    M_bubble   = 1'b0;
    halted     = 1'b0;

    case (state_reg)
      ST_RUN: begin
        // exc_w wins so a fault already in W skips the drain step.
        if (exc_w) begin
          state_next = ST_STOPPED;
        end else if (exc_m) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (exc_w) begin
          state_next = ST_STOPPED;
        end
      end
      ST_STOPPED: begin
        state_next = ST_STOPPED;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase

    // Capture the faulting status only on entry so it holds afterwards.
    if ((state_next == ST_STOPPED) && (state_reg != ST_STOPPED)) begin
      stat_next = W_stat;
    end

    if (rst) begin
      // Flush every stage with NOPs while reset is held.
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else if (state_reg == ST_STOPPED) begin
      F_stall = 1'b1;
      D_stall = 1'b1;
      W_stall = 1'b1;
      halted  = 1'b1;
    end else begin
      F_stall  = load_use || ret_pend;
      D_stall  = load_use;
      // A stall on D overrides any bubble request for the same register.
      D_bubble = (mispred || (ret_pend && !load_use)) && !load_use;
      E_bubble = mispred || load_use;
      M_bubble = exc_m || exc_w;
      W_stall  = exc_w;
    end
  end

  assign stat_out = stat_reg;

  // Performance counters: index 0 cycles, 1 stalls, 2 bubbles, 3 mispredicts.
  logic             count_en;
  logic [NUM_CNT-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_reg [NUM_CNT];

  assign count_en = (state_reg != ST_STOPPED);
  assign cnt_inc  = {mispred, (D_bubble || E_bubble), F_stall, 1'b1};

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (count_en && cnt_inc[gi]) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign cyc_cnt     = cnt_reg[0];
  assign stall_cnt   = cnt_reg[1];
  assign bubble_cnt  = cnt_reg[2];
  assign mispred_cnt = cnt_reg[3];

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 core. Each cycle it decodes the icodes, register IDs and status codes held in the D/E/M/W pipeline registers and drives the stall and bubble inputs of reg_F, reg_D, reg_E, reg_M and reg_W. It resolves load-use hazards, `ret` hazards, mispredicted jumps and exception/halt propagation. A small run-state machine freezes the pipeline once a non-AOK status reaches write-back, and a set of performance counters records the core's behaviour.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- D_icode  in  4  icode in the decode register.
- d_srcA, d_srcB  in  4  decode-stage source register IDs; 0xF means none.
- E_icode  in  4  icode in the execute register.
- E_dstM  in  4  memory-load destination in the execute register.
- e_cnd  in  1  condition outcome computed in execute.
- M_icode  in  4  icode in the memory register.
- m_stat  in  2  status produced by the memory stage.
- W_stat  in  2  status in the write-back register.
- F_stall, D_stall, W_stall  out  1  hold the corresponding pipeline register.
- D_bubble, E_bubble, M_bubble  out  1  load NOP (icode 1) into the corresponding register.
- halted  out  1  high in the STOPPED state.
- stat_out  out  2  architectural status latched when the core stops.
- cyc_cnt, stall_cnt, bubble_cnt, mispred_cnt  out  CNT_W  performance counters.

## Operation
- Stat encodings: AOK=0, HLT=1, ADR=2, INS=3.
- icodes used here: JXX=7, RET=9, MRMOVQ=5, POPQ=0xB. RNONE=0xF.

Hazard terms:
- load_use = E_icode∈{MRMOVQ,POPQ} ∧ E_dstM≠RNONE ∧ E_dstM∈{d_srcA,d_srcB}.
- ret_pend = RET∈{D_icode,E_icode,M_icode}.
- mispred = E_icode==JXX ∧ !e_cnd.
- exc_m = m_stat≠AOK.
- exc_w = W_stat≠AOK.

RUN state outputs:
- F_stall = load_use ∨ ret_pend.
- D_stall = load_use.
- D_bubble = mispred ∨ (ret_pend ∧ !load_use).
- E_bubble = mispred ∨ load_use.
- M_bubble = exc_m ∨ exc_w.
- W_stall = exc_w.
- Stall has priority over bubble for the same register: D_stall=1 forces D_bubble=0.

FSM states: RUN, DRAIN, STOPPED.
- RUN→DRAIN when exc_m ∧ !exc_w.
- RUN→STOPPED when exc_w; DRAIN→STOPPED when exc_w.
- DRAIN keeps the RUN output equations. M_bubble stays high, so no younger instruction commits memory.
- STOPPED: F_stall=D_stall=W_stall=1, all bubbles=0, halted=1. The state persists until rst.
- stat_out is loaded with W_stat on the transition into STOPPED and otherwise holds its value.

Counters:
- Count only in RUN and DRAIN. All four are frozen in STOPPED.
- Wrap modulo 2^CNT_W.
- cyc_cnt +1 every counted cycle.
- stall_cnt +1 when F_stall.
- bubble_cnt +1 when D_bubble ∨ E_bubble.
- mispred_cnt +1 when mispred.

## Timing
- Control outputs are combinational from the current pipeline-register contents and take effect at the next clk edge.
- While rst=1, outputs override all other logic: D_bubble=E_bubble=M_bubble=1, F_stall=D_stall=W_stall=0, halted=0. This flushes the pipe with NOPs.
- Registered reset values on the rst edge: state=RUN, stat_out=AOK, all counters 0.
- rst asserted in any state, including STOPPED mid-drain, returns the block to RUN the following cycle.
- Counter and stat_out latency: one cycle. A value reflects the previous cycle's events.
- Simultaneous events:
  - load_use ∧ ret_pend: stall F/D, bubble E, no D bubble.
  - mispred ∧ ret_pend: D_bubble=1 and F_stall=1. The RET is in D, so the squash wins.
  - exc_m ∧ exc_w: go directly to STOPPED.

## Structure
- Package y86_pkg holds the icode constants, the stat enum, RNONE and the fsm state typedef. The package is shared with the stage registers.
- Sub-module pipe_hazard: purely combinational; produces load_use, ret_pend and mispred. pipe_ctrl holds the FSM, the output muxing and the counters.

## Test plan
- Load-use: E_icode=5, E_dstM=3, d_srcA=3 → F_stall=D_stall=E_bubble=1, D_bubble=0; stall_cnt +1, bubble_cnt +1 next cycle.
- Ret sequence: RET in D, then E, then M over three cycles, no load_use → F_stall=1 and D_bubble=1 each cycle; bubble_cnt +3.
- Mispredict: E_icode=7, e_cnd=0, D_icode=9 → D_bubble=E_bubble=1, F_stall=1; mispred_cnt +1.
- Halt drain: m_stat=HLT for one cycle, then W_stat=HLT → state DRAIN with M_bubble=1, then STOPPED; halted=1, stat_out=1, counters frozen over 10 further cycles.
- Reset from STOPPED: rst=1 for one cycle → bubbles high during reset; afterwards halted=0, stat_out=0, cyc_cnt counts 0,1,2…
- Wrap: CNT_W=4, run 17 cycles → cyc_cnt=1.
